// File: rtl/led_pkg.sv
// Shared types and constants for the LED bar driver.
package led_pkg;

  // Driver FSM states
  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FLASH  = 1'b1
  } state_e;

  // Pin level that lights an LED (the bar is wired active-low)
  localparam logic LED_ON = 1'b0;

endpackage

// File: rtl/led_bar_driver_if.sv
// Counter-side inputs and pin-side outputs of the LED bar driver.
interface led_bar_driver_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PWM_BITS = 4
);

  logic [WIDTH-1:0]    count_in;
  logic                count_valid;
  logic [PWM_BITS-1:0] brightness;
  logic                flash_en;
  logic [WIDTH-1:0]    led_n;
  logic                wrap_pulse;
  logic                flashing;

  modport master (
    output count_in, count_valid, brightness, flash_en,
    input  led_n, wrap_pulse, flashing
  );

  modport slave (
    input  count_in, count_valid, brightness, flash_en,
    output led_n, wrap_pulse, flashing
  );

endinterface

// File: rtl/led_bar_driver_pwm.sv
// PWM timebase: prescaler, frame position counter and frame-end strobe.
module pwm_tick_gen #(
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned TICK_DIV = 100
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                frame_end_c
);

  localparam int unsigned         PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]     PS_MAX  = PS_W'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PS_W-1:0] prescaler;
  logic            tick_c;

  // One tick per TICK_DIV clocks; the frame ends on the tick that leaves the last slot
  assign tick_c      = (prescaler == PS_MAX);
  assign frame_end_c = tick_c && (pwm_cnt == CNT_MAX);

  // Prescaler and frame position, both free-running
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick_c ? '0 : prescaler + PS_W'(1);
      if (tick_c) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/led_bar_driver.sv
// Latches the upstream count and drives the active-low LED bar with PWM dimming,
// flashing the whole bar for a few frames when the count wraps.
module led_bar_driver
  import led_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PWM_BITS     = 4,
  parameter int unsigned TICK_DIV     = 100,
  parameter int unsigned FLASH_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset,
  led_bar_driver_if.slave  bus
);

  localparam logic [0:0]          S_NORMAL  = 1'(NORMAL);
  localparam logic [0:0]          S_FLASH   = 1'(FLASH);
  localparam logic [WIDTH-1:0]    ALL_ONES  = '1;
  localparam logic [WIDTH-1:0]    ALL_ZERO  = '0;
  localparam logic [PWM_BITS-1:0] BR_MAX    = '1;
  localparam logic [WIDTH-1:0]    LEDS_DARK = {WIDTH{~LED_ON}};
  localparam int unsigned         FC_W      = $clog2(FLASH_FRAMES + 1);
  localparam logic [FC_W-1:0]     FC_LAST   = FC_W'(FLASH_FRAMES - 1);

  logic [0:0]          state_q, state_d;
  logic [FC_W-1:0]     flash_cnt, flash_cnt_d;
  logic                phase, phase_d;
  logic [WIDTH-1:0]    shadow;
  logic [PWM_BITS-1:0] br_reg;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                frame_end_c;
  logic [WIDTH-1:0]    lit_c;
  logic                wrap_c;
  logic                on_phase_c;
  logic [WIDTH-1:0]    led_q;
  logic                wrap_q;
  logic                flashing_q;

  pwm_tick_gen #(
    .PWM_BITS (PWM_BITS),
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk         (clk),
    .reset       (reset),
    .pwm_cnt     (pwm_cnt),
    .frame_end_c (frame_end_c)
  );

  // Wrap is judged against the count held before this capture; shadow=0 after reset
  // makes a first capture of all-ones a wrap
  assign wrap_c = bus.count_valid &&
                  (((shadow == ALL_ONES) && (bus.count_in == ALL_ZERO)) ||
                   ((shadow == ALL_ZERO) && (bus.count_in == ALL_ONES)));

  // Full-scale brightness stays lit for the whole frame, including the last slot
  assign on_phase_c = (br_reg == BR_MAX) || (pwm_cnt < br_reg);

  // Next-state, flash sequencing and LED pattern selection
  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt;
    phase_d     = phase;
    lit_c       = '0;
    case (state_q)
      S_NORMAL: begin
        lit_c = shadow & {WIDTH{on_phase_c}};
        if (wrap_c && bus.flash_en) begin
          state_d     = S_FLASH;
          flash_cnt_d = '0;
          phase_d     = 1'b1;
        end
      end
      S_FLASH: begin
        lit_c = {WIDTH{phase & on_phase_c}};
        if (wrap_c) begin
          flash_cnt_d = '0;
          phase_d     = 1'b1;
        end else if (frame_end_c) begin
          phase_d     = ~phase;
          flash_cnt_d = flash_cnt + FC_W'(1);
          if (flash_cnt == FC_LAST) begin
            state_d = S_NORMAL;
          end
        end
      end
      default: state_d = S_NORMAL;
    endcase
  end

  // State, capture, duty latch and registered pin outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_NORMAL;
      flash_cnt  <= '0;
      phase      <= 1'b0;
      shadow     <= '0;
      br_reg     <= '0;
      led_q      <= LEDS_DARK;
      wrap_q     <= 1'b0;
      flashing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flash_cnt  <= flash_cnt_d;
      phase      <= phase_d;
      if (bus.count_valid) begin
        shadow <= bus.count_in;
      end
      if (frame_end_c) begin
        br_reg <= bus.brightness;
      end
      led_q      <= lit_c ^ LEDS_DARK;
      wrap_q     <= wrap_c;
      flashing_q <= (state_d == S_FLASH);
    end
  end

  assign bus.led_n      = led_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.flashing   = flashing_q;

endmodule

// File: tb/tb_led_bar_driver.sv
// Directed bench for led_bar_driver with TICK_DIV=2, PWM_BITS=4, FLASH_FRAMES=4.
// cyc counts clock edges since reset release, so a PWM frame spans cyc 32k..32k+31.
module tb_led_bar_driver;

  logic        clk;
  logic        reset;
  int unsigned cyc;
  int unsigned n_chk;
  int unsigned n_pass;

  led_bar_driver_if #(.WIDTH(8), .PWM_BITS(4)) bus ();

  led_bar_driver #(
    .WIDTH        (8),
    .PWM_BITS     (4),
    .TICK_DIV     (2),
    .FLASH_FRAMES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index since reset release
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cyc %0d", tag, got, exp, cyc);
  endtask

  task automatic goto(input int unsigned t);
    int unsigned guard;
    guard = 0;
    while (cyc != t) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        $display("FAIL goto: cyc %0d never reached %0d", cyc, t);
        $fatal(1, "bench stalled");
      end
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    bus.count_in    = v;
    bus.count_valid = 1'b1;
    @(negedge clk);
    bus.count_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    bus.count_in = '0;
    bus.count_valid = 1'b0;
    bus.brightness = '0;
    bus.flash_en = 1'b0;

    // 1: reset held
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_led", bus.led_n, 8'hFF);
      check("rst_wrap", bus.wrap_pulse, 0);
      check("rst_flashing", bus.flashing, 0);
    end
    reset = 1'b0;
    bus.brightness = 4'd15;

    // 2: full brightness, latency and steady value
    goto(32);
    strobe(8'hA5);
    check("lat_n1_led", bus.led_n, 8'hFF);
    check("a5_wrap", bus.wrap_pulse, 0);
    for (int s = 34; s < 100; s++) begin
      goto(s);
      check("a5_led", bus.led_n, 8'h5A);
    end

    // 3: brightness 4 set mid-frame, applied from the next frame
    goto(100);
    bus.brightness = 4'd4;
    strobe(8'h0F);
    check("br4_old_led", bus.led_n, 8'h5A);
    for (int s = 102; s <= 128; s++) begin
      goto(s);
      check("br4_midframe_led", bus.led_n, 8'hF0);
    end
    for (int s = 129; s < 200; s++) begin
      goto(s);
      e = (((s - 1) % 32) < 8) ? 8'hF0 : 8'hFF;
      check("br4_pwm_led", bus.led_n, e);
    end

    // 4: up-wrap with flash enabled; flash_en drops mid-flash
    goto(200);
    bus.brightness = 4'd15;
    goto(225);
    bus.flash_en = 1'b1;
    strobe(8'hFF);
    goto(255);
    check("pre_wrap", bus.wrap_pulse, 0);
    check("pre_flashing", bus.flashing, 0);
    strobe(8'h00);
    for (int s = 256; s <= 390; s++) begin
      goto(s);
      if (s == 300) bus.flash_en = 1'b0;
      if (s == 256)      e = 8'h00;
      else if (s <= 384) e = ((((s - 257) / 32) % 2) == 0) ? 8'h00 : 8'hFF;
      else               e = 8'hFF;
      check("flash_led", bus.led_n, e);
      check("flash_flashing", bus.flashing, (s <= 383) ? 1 : 0);
      check("flash_wrap", bus.wrap_pulse, (s == 256) ? 1 : 0);
    end

    // 5: down-wrap with flash disabled
    goto(399);
    strobe(8'h00);
    check("nowrap_0_0", bus.wrap_pulse, 0);
    strobe(8'hFF);
    check("dwrap_pulse", bus.wrap_pulse, 1);
    check("dwrap_flashing", bus.flashing, 0);
    check("dwrap_led_n1", bus.led_n, 8'hFF);
    @(negedge clk);
    check("dwrap_pulse_end", bus.wrap_pulse, 0);
    check("dwrap_flashing2", bus.flashing, 0);
    check("dwrap_led", bus.led_n, 8'h00);

    // 6: second wrap in flash frame 2 restarts the flash
    bus.flash_en = 1'b1;
    goto(415);
    strobe(8'h00);
    check("f2_wrap", bus.wrap_pulse, 1);
    check("f2_flashing", bus.flashing, 1);
    goto(460);
    check("f2_led_dark", bus.led_n, 8'hFF);
    goto(490);
    check("f2_led_lit", bus.led_n, 8'h00);
    strobe(8'hFF);
    for (int s = 491; s <= 615; s++) begin
      goto(s);
      if (s <= 512)      e = 8'h00;
      else if (s <= 544) e = 8'hFF;
      else if (s <= 576) e = 8'h00;
      else if (s <= 608) e = 8'hFF;
      else               e = 8'h00;
      check("restart_led", bus.led_n, e);
      check("restart_flashing", bus.flashing, (s <= 607) ? 1 : 0);
      check("restart_wrap", bus.wrap_pulse, (s == 491) ? 1 : 0);
    end

    // Reset while flashing
    goto(639);
    strobe(8'h00);
    check("f3_flashing", bus.flashing, 1);
    goto(660);
    check("f3_led", bus.led_n, 8'h00);
    check("f3_flashing2", bus.flashing, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_led", bus.led_n, 8'hFF);
    check("midrst_flashing", bus.flashing, 0);
    check("midrst_wrap", bus.wrap_pulse, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_led", bus.led_n, 8'hFF);
      check("postrst_flashing", bus.flashing, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
